turn_lamp_decoder: RTL and testbench
====================================

# turn_lamp_decoder

Receive-side companion to the turn-signal FSM. Samples the blinking lamp lines `D` and `I` and recovers the active mode, encoded identically to the FSM's `Status`. It also flags per-lamp faults: a stuck-on lamp, and hyperflash from a blink period that is too short. Sits on the dashboard/diagnostic side and observes the lamp wires only; there is no connection to the lever or emergency inputs.

## Interface
- `TICK_DIV`, 5_000_000: clk cycles per tick (100 ms at 50 MHz).
- `TIMEOUT_TICKS`, 30: ticks without a rising edge before a lamp is declared inactive.
- `MIN_PERIOD_TICKS`, 12: minimum legal rising-to-rising spacing. The nominal spacing is 20.
- `STUCK_TICKS`, 25: continuous-high ticks that declare a lamp stuck.
- `clk  input  1`: board clock, 50 MHz.
- `reset  input  1`: synchronous, active-low reset.
- `D  input  1`: right lamp line, asynchronous to `clk`.
- `I  input  1`: left lamp line, asynchronous to `clk`.
- `Status  output  2`: decoded mode. 00 off, 01 right, 10 left, 11 emergency.
- `changed  output  1`: one-cycle pulse in the cycle `Status` takes a new value.
- `fault_D  output  1`: sticky fault on the right lamp.
- `fault_I  output  1`: sticky fault on the left lamp.

## Operation
- Each lamp line goes through:
  - a 2-flop synchronizer;
  - a rising/falling edge detector on the synchronized value.
- A free-running tick counter (0..`TICK_DIV`-1) pulses `tick` for one cycle when it wraps.
- Each lamp channel keeps the following state:
  - `seen`: at least one rising edge observed since reset.
  - `since_edge`: ticks since the last rising edge. Increments on `tick` and saturates at `TIMEOUT_TICKS`.
  - `high_cnt`: ticks spent continuously high. Cleared while the lamp is low; saturates at `STUCK_TICKS`.
  - `active`: equals `seen && since_edge < TIMEOUT_TICKS`.
- On a rising edge, `since_edge` is set to 0. If an edge and a tick land in the same cycle, the edge wins: the result is 0, not 1.
- Stuck fault: when `high_cnt` reaches `STUCK_TICKS`, the channel fault flag sets and stays set until reset.
- Decode FSM has states OFF, RIGHT, LEFT and EMERG. The candidate state is derived from the active flags:
  - neither active → OFF;
  - D only → RIGHT;
  - I only → LEFT;
  - both → EMERG.
- Confirmation rule:
  - On every `tick`, the current candidate is stored as `prev_cand`.
  - The state advances only on a `tick` where candidate equals `prev_cand` and differs from the current state, i.e. two consecutive matching samples.
  - Any transition between any two states is legal.
- `Status` is the state encoding, registered. `changed` is asserted in the update cycle only.

## Timing
- All outputs reset to 0, and `Status` = 00 (OFF).
- Every counter, synchronizer flop, `seen`, `prev_cand` and fault flag clears in the first clk edge with `reset`=0.
- Edge latency: a pin transition is visible at the edge detector 2 cycles later; `active` updates on the 3rd cycle.
- Mode-change latency: `Status` updates on the 2nd `tick` after the candidate changes. That is at most 2×`TICK_DIV` + 3 cycles after the first qualifying edge.
- Drop-out latency: `Status` leaves a mode (`TIMEOUT_TICKS` + 2) ticks after the last rising edge, ±1 tick.
- Reset mid-operation:
  - the block returns to OFF with faults cleared;
  - a lamp already high at reset release is seen as a rising edge 2 cycles after release;
  - `high_cnt` restarts from 0.
- Simultaneous stuck and hyperflash conditions on the same lamp set the same flag. There is no priority.

## Configuration
- `HYPERFLASH_DET_EN` defined:
  - on a rising edge with `seen`=1 and `since_edge` < `MIN_PERIOD_TICKS`, the channel fault flag sets;
  - this check is evaluated before `since_edge` clears.
- Undefined: only the stuck fault exists. The period check and its comparator are not compiled.

## Structure
- Package `turn_lamp_pkg` holds:
  - the mode encodings OFF/RIGHT/LEFT/EMERG (00/01/10/11, identical to the FSM's state codes);
  - the default parameter values.
- Sub-module `lamp_channel`, instantiated twice. It contains the synchronizer, edge detect, `seen`, `since_edge`, `high_cnt`, `active` and the fault flag.
- The top level holds the tick divider, the candidate/confirm logic and the output registers.

## Test plan
Bench parameters: `TICK_DIV`=10, other parameters at default. Nominal lamp drive is 100 clk high / 100 clk low.
- Release reset, hold D=I=0 for 2000 clk → `Status`=00, `changed` never pulses, both faults 0.
- Drive D nominal, I=0 → `Status`=01 within 23 clk of the first D rise, exactly one `changed` pulse, `fault_D`=0.
- Drive D and I nominal and in phase; after `Status`=11, hold I=0 → `Status` goes to 01 between 310 and 330 clk after the last I rise.
- Drive D at 30 high / 30 low:
  - with `HYPERFLASH_DET_EN` → `fault_D`=1 on the 2nd D rise, and `Status`=01 still decodes;
  - without it → `fault_D` stays 0.
- Hold I high for 300 clk then low → `fault_I`=1 about 250 clk after the rise and stays set; `Status` returns to 00 after timeout.
- In `Status`=11 with D high, pulse `reset`=0 for one cycle → next cycle `Status`=00 and faults 0. D is detected as a rise 2 cycles after release, and `Status` returns to 11 once I pulses.

Source files
------------

// File: rtl/turn_lamp_pkg.sv
// rtl/turn_lamp_pkg.sv - mode encodings, default parameters and candidate helper for turn_lamp_decoder
package turn_lamp_pkg;

  // Mode codes match the turn-signal FSM state codes so Status can be compared directly.
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_EMERG = 2'b11;

  localparam int DEF_TICK_DIV         = 5_000_000;
  localparam int DEF_TIMEOUT_TICKS    = 30;
  localparam int DEF_MIN_PERIOD_TICKS = 12;
  localparam int DEF_STUCK_TICKS      = 25;

  // Candidate mode from the two per-lamp activity flags.
  function automatic logic [1:0] mode_of(input logic act_d, input logic act_i);
    logic [1:0] m;
    case ({act_i, act_d})
      2'b01:   m = MODE_RIGHT;
      2'b10:   m = MODE_LEFT;
      2'b11:   m = MODE_EMERG;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/turn_lamp_decoder_if.sv
// rtl/turn_lamp_decoder_if.sv - lamp-line inputs and decoded outputs of turn_lamp_decoder
// Signals: D, I (lamp lines, async); Status[1:0], changed, fault_D, fault_I (decoder results).
// Modports: master = lamp side / observer, slave = decoder.
interface turn_lamp_decoder_if;
  logic       D;
  logic       I;
  logic [1:0] Status;
  logic       changed;
  logic       fault_D;
  logic       fault_I;

  modport master (output D, I, input Status, changed, fault_D, fault_I);
  modport slave  (input D, I, output Status, changed, fault_D, fault_I);
endinterface

// File: rtl/lamp_channel.sv
// rtl/lamp_channel.sv - per-lamp synchronizer, edge detect, activity timeout and fault flag
// Ports: clk, reset (sync active-low), tick (divider strobe), lamp (async lamp line),
//        active (lamp blinking recently), fault (sticky stuck/hyperflash flag).
// Optional: HYPERFLASH_DET_EN adds the minimum-period check on rising edges.
module lamp_channel #(
  parameter int TIMEOUT_TICKS    = 30,
`ifdef HYPERFLASH_DET_EN
  parameter int MIN_PERIOD_TICKS = 12,
`endif
  parameter int STUCK_TICKS      = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic lamp,
  output logic active,
  output logic fault
);

  localparam int SW = $clog2(TIMEOUT_TICKS + 1);
  localparam int HW = $clog2(STUCK_TICKS + 1);

  logic          sync_1;
  logic          sync_2;
  logic          sync_prev;
  logic          rise;
  logic          seen;
  logic [SW-1:0] since_edge;
  logic [HW-1:0] high_cnt;

  // sync_prev clears with reset, so a lamp already high at release reads as a rise.
  assign rise   = sync_2 & ~sync_prev;
  assign active = seen && (since_edge < SW'(TIMEOUT_TICKS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      sync_prev  <= 1'b0;
      seen       <= 1'b0;
      since_edge <= '0;
      high_cnt   <= '0;
      fault      <= 1'b0;
    end else begin
      sync_1    <= lamp;
      sync_2    <= sync_1;
      sync_prev <= sync_2;

      // A rise beats a coincident tick: the count restarts at 0.
      if (rise) begin
        seen       <= 1'b1;
        since_edge <= '0;
      end else if (tick && since_edge < SW'(TIMEOUT_TICKS)) begin
        since_edge <= since_edge + 1'b1;
      end

      if (!sync_2) begin
        high_cnt <= '0;
      end else if (tick && high_cnt < HW'(STUCK_TICKS)) begin
        high_cnt <= high_cnt + 1'b1;
      end

      if (high_cnt == HW'(STUCK_TICKS)) begin
        fault <= 1'b1;
      end
`ifdef HYPERFLASH_DET_EN
      // Uses since_edge before this rise clears it.
      if (rise && seen && since_edge < SW'(MIN_PERIOD_TICKS)) begin
        fault <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/turn_lamp_decoder.sv
// rtl/turn_lamp_decoder.sv - recovers turn-signal mode and lamp faults from the D/I lamp lines
// Ports: clk, reset (sync active-low), bus (turn_lamp_decoder_if.slave: D, I in;
//        Status, changed, fault_D, fault_I out).
// Optional: HYPERFLASH_DET_EN enables the short-period fault in both lamp channels.
module turn_lamp_decoder
  import turn_lamp_pkg::*;
#(
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int TIMEOUT_TICKS    = DEF_TIMEOUT_TICKS,
`ifdef HYPERFLASH_DET_EN
  parameter int MIN_PERIOD_TICKS = DEF_MIN_PERIOD_TICKS,
`endif
  parameter int STUCK_TICKS      = DEF_STUCK_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  turn_lamp_decoder_if.slave  bus
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          act_d;
  logic          act_i;
  logic          flt_d;
  logic          flt_i;
  logic [1:0]    cand;
  logic [1:0]    prev_cand;
  logic [1:0]    state;
  logic          chg;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  lamp_channel #(
    .TIMEOUT_TICKS    (TIMEOUT_TICKS),
`ifdef HYPERFLASH_DET_EN
    .MIN_PERIOD_TICKS (MIN_PERIOD_TICKS),
`endif
    .STUCK_TICKS      (STUCK_TICKS)
  ) u_ch_d (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .lamp   (bus.D),
    .active (act_d),
    .fault  (flt_d)
  );

  lamp_channel #(
    .TIMEOUT_TICKS    (TIMEOUT_TICKS),
`ifdef HYPERFLASH_DET_EN
    .MIN_PERIOD_TICKS (MIN_PERIOD_TICKS),
`endif
    .STUCK_TICKS      (STUCK_TICKS)
  ) u_ch_i (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .lamp   (bus.I),
    .active (act_i),
    .fault  (flt_i)
  );

  assign cand = mode_of(act_d, act_i);

  // A new mode must be seen on two consecutive ticks before the state follows it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= MODE_OFF;
      prev_cand <= MODE_OFF;
      chg       <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (tick) begin
        prev_cand <= cand;
        if (cand == prev_cand && cand != state) begin
          state <= cand;
          chg   <= 1'b1;
        end
      end
    end
  end

  assign bus.Status  = state;
  assign bus.changed = chg;
  assign bus.fault_D = flt_d;
  assign bus.fault_I = flt_i;

endmodule

// File: tb/tb_turn_lamp_decoder.sv
// tb/tb_turn_lamp_decoder.sv - directed vector bench for turn_lamp_decoder with TICK_DIV=10
module tb_turn_lamp_decoder;

`ifdef HYPERFLASH_DET_EN
  localparam int HF = 1;
`else
  localparam int HF = 0;
`endif

  typedef struct {
    int d_mode;
    int d_hi;
    int d_lo;
    int i_mode;
    int i_hi;
    int i_lo;
    int cycles;
    int st;
    int chg;
    int fd;
    int fi;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  turn_lamp_decoder_if bus ();

  turn_lamp_decoder #(.TICK_DIV(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_chg = 0;
  int last_d_rise = 0;
  int last_i_rise = 0;
  int d_mode = 0, d_hi = 1, d_lo = 1, d_ph = 0;
  int i_mode = 0, i_hi = 1, i_lo = 1, i_ph = 0;
  vec_t vecs[8];

  function automatic vec_t mk(int dm, int dh, int dl, int im, int ih, int il, int n,
                              int st, int chg, int fd, int fi);
    vec_t v;
    v.d_mode = dm; v.d_hi = dh; v.d_lo = dl;
    v.i_mode = im; v.i_hi = ih; v.i_lo = il;
    v.cycles = n; v.st = st; v.chg = chg; v.fd = fd; v.fi = fi;
    return v;
  endfunction

  // mode 0: held low, 1: held high, 2: blink hi/lo cycles starting high
  function automatic logic lamp_val(int mode, int hi, int ph);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return (ph < hi);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    logic dn, in_;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.changed === 1'b1) n_chg++;
    dn  = lamp_val(d_mode, d_hi, d_ph);
    in_ = lamp_val(i_mode, i_hi, i_ph);
    if (d_mode == 2) d_ph = (d_ph + 1) % (d_hi + d_lo);
    if (i_mode == 2) i_ph = (i_ph + 1) % (i_hi + i_lo);
    if (dn && !bus.D) last_d_rise = cyc;
    if (in_ && !bus.I) last_i_rise = cyc;
    bus.D = dn;
    bus.I = in_;
  endtask

  task automatic set_lamps(input int dm, input int dh, input int dl,
                           input int im, input int ih, input int il);
    d_mode = dm; d_hi = dh; d_lo = dl; d_ph = 0;
    i_mode = im; i_hi = ih; i_lo = il; i_ph = 0;
  endtask

  task automatic reset_dut();
    set_lamps(0, 1, 1, 0, 1, 1);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    n_chg = 0;
  endtask

  task automatic wait_status(input logic [1:0] v, input int budget, output int n);
    n = 0;
    while (bus.Status !== v && n < budget) begin
      step();
      n++;
    end
  endtask

  int n;
  int dt;
  int t0;

  initial begin
    bus.D = 1'b0;
    bus.I = 1'b0;

    vecs[0] = mk(0, 1,   1,   0, 1,   1,   2000, 0, 0, 0,  0);
    vecs[1] = mk(2, 100, 100, 0, 1,   1,   600,  1, 1, 0,  0);
    vecs[2] = mk(0, 1,   1,   2, 100, 100, 600,  2, 1, 0,  0);
    vecs[3] = mk(2, 100, 100, 2, 100, 100, 600,  3, 1, 0,  0);
    vecs[4] = mk(2, 30,  30,  0, 1,   1,   600,  1, 1, HF, 0);
    vecs[5] = mk(0, 1,   1,   1, 1,   1,   400,  0, 2, 0,  1);
    vecs[6] = mk(1, 1,   1,   0, 1,   1,   200,  1, 1, 0,  0);
    vecs[7] = mk(2, 30,  30,  2, 100, 100, 600,  3, 1, HF, 0);

    // Reset state
    reset_dut();
    check("reset_status",  int'(bus.Status),  0);
    check("reset_changed", int'(bus.changed), 0);
    check("reset_fault_D", int'(bus.fault_D), 0);
    check("reset_fault_I", int'(bus.fault_I), 0);

    // Steady-state vectors, each from a fresh reset
    for (int k = 0; k < 8; k++) begin
      reset_dut();
      set_lamps(vecs[k].d_mode, vecs[k].d_hi, vecs[k].d_lo,
                vecs[k].i_mode, vecs[k].i_hi, vecs[k].i_lo);
      repeat (vecs[k].cycles) step();
      check($sformatf("vec%0d_status", k),  int'(bus.Status),  vecs[k].st);
      check($sformatf("vec%0d_changes", k), n_chg,             vecs[k].chg);
      check($sformatf("vec%0d_fault_D", k), int'(bus.fault_D), vecs[k].fd);
      check($sformatf("vec%0d_fault_I", k), int'(bus.fault_I), vecs[k].fi);
    end

    // Mode-change latency from the first D rise
    reset_dut();
    set_lamps(2, 100, 100, 0, 1, 1);
    step();
    t0 = last_d_rise;
    wait_status(2'b01, 60, n);
    check("right_reached", int'(bus.Status), 1);
    check_rng("right_latency", cyc - t0, 14, 23);

    // Drop-out from emergency to right after I stops
    reset_dut();
    set_lamps(2, 100, 100, 2, 100, 100);
    wait_status(2'b11, 60, n);
    check("emerg_reached", int'(bus.Status), 3);
    i_mode = 0;
    n_chg = 0;
    wait_status(2'b01, 500, n);
    check("dropout_status", int'(bus.Status), 1);
    dt = cyc - last_i_rise;
    check_rng("dropout_latency", dt, 310, 330);
    check("dropout_changes", n_chg, 1);

    // Stuck-high left lamp
    reset_dut();
    set_lamps(0, 1, 1, 1, 1, 1);
    step();
    t0 = last_i_rise;
    n = 0;
    while (bus.fault_I !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("stuck_fault_I", int'(bus.fault_I), 1);
    check_rng("stuck_latency", cyc - t0, 240, 270);
    while (cyc - t0 < 300) step();
    i_mode = 0;
    repeat (500) step();
    check("stuck_fault_I_held", int'(bus.fault_I), 1);
    check("stuck_status_off",   int'(bus.Status),  0);
    check("stuck_fault_D",      int'(bus.fault_D), 0);

    // Reset pulse in emergency with D held high
    reset_dut();
    set_lamps(2, 100, 100, 2, 100, 100);
    wait_status(2'b11, 60, n);
    check("rst_emerg_reached", int'(bus.Status), 3);
    d_mode = 1;
    i_mode = 0;
    repeat (5) step();
    n_chg = 0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_status",  int'(bus.Status),  0);
    check("rst_changed", int'(bus.changed), 0);
    check("rst_fault_D", int'(bus.fault_D), 0);
    check("rst_fault_I", int'(bus.fault_I), 0);
    repeat (5) step();
    i_mode = 2;
    i_hi = 100;
    i_lo = 100;
    i_ph = 0;
    wait_status(2'b11, 60, n);
    check("rst_emerg_again", int'(bus.Status),  3);
    check("rst_fault_D_after", int'(bus.fault_D), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
